// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes match the controller decode; state codes are reused by debug tooling.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    function automatic logic op_is_div(op_e o);
        return (o == OP_DIVU) || (o == OP_DIV);
    endfunction

    function automatic logic op_is_signed(op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negate; used as |x| at operand capture and as sign restore in FIX.
// Purely combinational, no backpressure.
module mdu_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + 1'b1) : i_val;

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO: one step per cycle, 32 RUN + 1 FIX.
// done pulses 34 cycles after start is sampled; start and MT writes are dropped while busy.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mt_we,
    input  logic             mt_hi,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = 2 * WIDTH + 1;

    state_e           r_state;
    op_e              r_op;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_acc;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_busy;
    logic             r_done;

    op_e              w_op;
    logic             w_rs_neg;
    logic             w_rt_neg;
    logic             w_dz;
    logic [WIDTH-1:0] w_rs_abs;
    logic [WIDTH-1:0] w_rt_abs;

    assign w_op     = op_e'(op);
    assign w_rs_neg = op_is_signed(w_op) & rs_val[WIDTH-1];
    assign w_rt_neg = op_is_signed(w_op) & rt_val[WIDTH-1];
    assign w_dz     = op_is_div(w_op) && (rt_val == '0);

    mdu_signfix #(.W(WIDTH)) u_abs_rs (.i_val(rs_val), .i_neg(w_rs_neg), .o_val(w_rs_abs));
    mdu_signfix #(.W(WIDTH)) u_abs_rt (.i_val(rt_val), .i_neg(w_rt_neg), .o_val(w_rt_abs));

    // Multiply: LSB-first shift-add, carry lands in the top bit before the right shift.
    logic [WIDTH:0]   w_mul_sum;
    logic [AW-1:0]    w_mul_next;
    assign w_mul_sum  = r_acc[AW-1:WIDTH] + {1'b0, r_opnd};
    assign w_mul_next = r_acc[0] ? ({w_mul_sum, r_acc[WIDTH-1:0]} >> 1) : (r_acc >> 1);

    // Divide: restoring; quotient bits enter at the bottom as the dividend shifts up.
    logic [AW-1:0]    w_shl;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [AW-1:0]    w_div_next;
    assign w_shl      = {r_acc[AW-2:0], 1'b0};
    assign w_trial    = w_shl[AW-1:WIDTH] - {1'b0, r_opnd};
    assign w_fits     = w_shl[AW-1:WIDTH] >= {1'b0, r_opnd};
    assign w_div_next = w_fits ? {w_trial, w_shl[WIDTH-1:1], 1'b1} : w_shl;

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    mdu_signfix #(.W(2*WIDTH)) u_fix_prod (.i_val(r_acc[2*WIDTH-1:0]),     .i_neg(r_neg_q), .o_val(w_prod));
    mdu_signfix #(.W(WIDTH))   u_fix_quo  (.i_val(r_acc[WIDTH-1:0]),       .i_neg(r_neg_q), .o_val(w_quo));
    mdu_signfix #(.W(WIDTH))   u_fix_rem  (.i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_neg_r), .o_val(w_rem));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_MULTU;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (mt_we) begin
                        if (mt_hi) r_hi <= mt_data;
                        else       r_lo <= mt_data;
                    end
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_op    <= w_op;
                        r_cnt   <= '0;
                        // Divide-by-zero keeps the raw dividend so it falls out as the remainder.
                        r_acc   <= {{(WIDTH+1){1'b0}}, (w_dz ? rs_val : w_rs_abs)};
                        r_opnd  <= w_rt_abs;
                        r_neg_q <= (w_rs_neg ^ w_rt_neg) & ~w_dz;
                        r_neg_r <= w_rs_neg & op_is_div(w_op) & ~w_dz;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_acc <= op_is_div(r_op) ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    if (op_is_div(r_op)) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: scoreboard of expected {hi,lo} checked at each done pulse.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        mt_we = 1'b0;
    logic        mt_hi = 1'b0;
    logic [31:0] mt_data = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val),
        .mt_we(mt_we), .mt_hi(mt_hi), .mt_data(mt_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    // Reference {hi,lo} built from native arithmetic plus the two architected corner cases.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        case (op_e'(o))
            OP_MULTU: p = {32'h0, a} * {32'h0, b};
            OP_MULT:  p = 64'(sa * sb);
            OP_DIVU:  p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        if (push) exp_q.push_back(model(o, a, b));
        cyc = 0;
        busy_cnt = 0;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busy_cnt++;
            step();
        end
    endtask

    task automatic finish_op(input string tag);
        logic [63:0] e;
        wait_done();
        check({tag, "_lat"}, 64'(cyc), 64'd34);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, {hi, lo}, e);
        end else begin
            check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        launch(o, a, b, 1'b1);
        finish_op(tag);
        step();
    endtask

    initial begin
        bit seen;

        // reset state
        step(); step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst = 1'b1;
        step();

        // MULTU timing and result
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        finish_op("multu_ff");
        check("multu_busy_cycles", 64'(busy_cnt), 64'd33);
        check("multu_busy_at_done", 64'(busy), 64'd0);
        check("multu_hi_const", {32'h0, hi}, 64'hFFFF_FFFE);
        step();
        check("multu_done_pulse", 64'(done), 64'd0);

        do_op("mult_neg",   2'b01, 32'hFFFF_FFFD, 32'h0000_0007);
        do_op("div_neg",    2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
        do_op("divu_100_7", 2'b10, 32'h0000_0064, 32'h0000_0007);
        do_op("div_ovf",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op("divu_dz",    2'b10, 32'h0000_0005, 32'h0000_0000);
        do_op("div_dz",     2'b11, 32'hFFFF_FFF9, 32'h0000_0000);
        check("div_dz_const", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);
        do_op("mult_mixed", 2'b01, 32'h8000_0000, 32'h8000_0000);
        do_op("div_rem_neg", 2'b11, 32'h0000_0064, 32'hFFFF_FFF9);

        // MTHI while idle takes effect at the next edge
        mt_we = 1'b1; mt_hi = 1'b1; mt_data = 32'hCAFE_0001;
        step();
        mt_we = 1'b0;
        check("mthi_idle", 64'(hi), 64'hCAFE_0001);

        // reset at cycle 10 of a DIV; start/MT during reset are ignored
        launch(2'b11, 32'h7654_3210, 32'h0000_0013, 1'b0);
        repeat (9) step();
        rst = 1'b0; start = 1'b1; mt_we = 1'b1; mt_hi = 1'b0; mt_data = 32'h0000_AAAA;
        step();
        rst = 1'b1; start = 1'b0; mt_we = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        seen = 1'b0;
        repeat (45) begin
            step();
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        check("abort_hilo_hold", {hi, lo}, 64'd0);

        // MTLO with start in the same cycle; mid-RUN start and MTHI are dropped
        mt_we = 1'b1; mt_hi = 1'b0; mt_data = 32'h0000_1234;
        launch(2'b00, 32'd3, 32'd4, 1'b1);
        mt_we = 1'b0;
        check("mt_start_lo", 64'(lo), 64'h1234);
        check("mt_start_busy", 64'(busy), 64'd1);
        repeat (3) step();
        start = 1'b1; op = 2'b10; rs_val = 32'd100; rt_val = 32'd7;
        mt_we = 1'b1; mt_hi = 1'b1; mt_data = 32'h0000_DEAD;
        step();
        start = 1'b0; mt_we = 1'b0;
        check("midrun_mthi_dropped", 64'(hi), 64'd0);
        finish_op("mt_then_multu");
        step();
        check("midrun_start_dropped", 64'(busy), 64'd0);

        // back-to-back: start accepted in the DONE cycle
        launch(2'b10, 32'd1000, 32'd33, 1'b1);
        finish_op("b2b_first");
        launch(2'b01, 32'hFFFF_FFFF, 32'h0000_0005, 1'b1);
        finish_op("b2b_second");
        step();

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width (only 32 is required to work).
REQ-002 SHALL have port: clk  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port: start  in  1  launch operation; sampled only when busy=0.
REQ-005 SHALL have port: op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
REQ-006 SHALL have ports: rs_val, rt_val  in  32  operands, driven from register-file RD1/RD2; sampled with start.
REQ-007 SHALL have ports: mt_we, mt_hi, mt_data  in  1/1/32  MTHI (mt_hi=1) or MTLO (mt_hi=0) write.
REQ-008 SHALL have port: busy  out  1  high in RUN and FIX.
REQ-009 SHALL have port: done  out  1  one-cycle pulse, high in DONE.
REQ-010 SHALL have ports: hi, lo  out  32  architectural HI/LO, direct register outputs (MFHI/MFLO write-back source).

Function
REQ-011 SHALL implement FSM IDLE -> RUN -> FIX -> DONE -> IDLE.
REQ-012 SHALL accept start when state is IDLE or DONE: latch op, |rs| and |rt| (signed ops) or raw values (unsigned ops), and the sign flags; clear the 5-bit iteration counter; enter RUN.
REQ-013 SHALL remain in RUN for exactly 32 cycles, one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter 31 -> FIX.
REQ-014 SHALL apply sign fix-up in FIX (1 cycle), write hi/lo at the FIX->DONE edge, and then enter DONE; done SHALL be high in the 34th cycle after the start-sampling edge.
REQ-015 SHALL form MULT/MULTU results as a 64-bit product with {hi,lo} = product mod 2^64; MULT product SHALL be negated iff the operand signs differ.
REQ-016 SHALL set lo=quotient and hi=remainder for DIV/DIVU; for DIV, the quotient SHALL be negative iff the signs differ and the remainder SHALL take the sign of the dividend.
REQ-017 SHALL handle divide by zero (rt_val=0, DIV or DIVU) as follows: lo=0xFFFFFFFF and hi=rs_val unmodified, with no sign fix-up.
REQ-018 SHALL handle DIV overflow (0x80000000 / 0xFFFFFFFF) as follows: lo=0x80000000, hi=0x00000000.
REQ-019 SHALL ignore start while busy=1; the operation in flight SHALL continue undisturbed.
REQ-020 SHALL apply mt_we in the same cycle when busy=0; mt_we while busy=1 SHALL be dropped.
REQ-021 SHALL accept start and mt_we together when busy=0: the MT write SHALL take effect immediately, and the later result SHALL overwrite both hi and lo.
REQ-022 SHALL keep hi/lo unchanged in RUN, FIX and IDLE, except for accepted MT writes.
REQ-023 SHALL accept start in the DONE cycle, giving back-to-back operations with no IDLE gap.

Reset
REQ-024 SHALL, when rst=0 at a clk edge, set state=IDLE, counter=0, hi=0, lo=0, all internal datapath registers=0, busy=0 and done=0.
REQ-025 SHALL abort any in-flight operation on reset mid-operation, with no partial hi/lo update.
REQ-026 SHALL ignore start and mt_we while rst=0.

Structure
REQ-027 SHALL place the op encodings (MULTU/MULT/DIVU/DIV) and the FSM state encoding in shared package mdu_pkg, for reuse by the controller decode.
REQ-028 SHALL use one sub-module, mdu_signfix: a combinational absolute-value/conditional-negate helper used at operand capture and in FIX.
REQ-029 SHALL keep the iteration datapath in a single 65-bit shift register (remainder/product-high : quotient/product-low) plus a 32-bit operand register.

Verification
REQ-030 SHALL verify: MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 34 cycles after start, busy high for the 33 cycles before.
REQ-031 SHALL verify: MULT 0xFFFFFFFD*0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-032 SHALL verify: DIV 0xFFFFFFF9/0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 0x00000064/0x00000007 -> lo=0x0000000E, hi=0x00000002.
REQ-033 SHALL verify: DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 0x00000005/0 -> lo=0xFFFFFFFF, hi=0x00000005; DIV 0xFFFFFFF9/0 -> lo=0xFFFFFFFF, hi=0xFFFFFFF9.
REQ-034 SHALL verify: mt_we (LO=0x1234) then start MULTU 3*4 in the same cycle -> lo=0x1234 next cycle, lo=0x0000000C at done; a second start and mt_we issued mid-RUN are ignored.
REQ-035 SHALL verify: rst=0 at cycle 10 of a DIV -> next cycle busy=0, done=0, hi=lo=0, and done never pulses for the aborted operation; a start in the DONE cycle produces a second done exactly 34 cycles later.
